// File: rtl/cpu_control_if.sv
// Bus bundle between cpu_control and its environment: instruction memory,
// register-file selects and the ALU opcode/flag signals.
interface cpu_control_if;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic        alu_zero;
    logic        alu_carry;
    logic [11:0] pc;
    logic        imem_req;
    logic [2:0]  op_alu;
    logic [3:0]  ra_sel;
    logic [3:0]  rb_sel;
    logic [3:0]  rd_sel;
    logic        rf_we;
    logic        wd_sel;
    logic [15:0] imm;
    logic        flag_z;
    logic        flag_c;
    logic        halted;

    modport master (
        input  imem_rdata, imem_valid, alu_zero, alu_carry,
        output pc, imem_req, op_alu, ra_sel, rb_sel, rd_sel,
               rf_we, wd_sel, imm, flag_z, flag_c, halted
    );

    modport slave (
        output imem_rdata, imem_valid, alu_zero, alu_carry,
        input  pc, imem_req, op_alu, ra_sel, rb_sel, rd_sel,
               rf_we, wd_sel, imm, flag_z, flag_c, halted
    );
endinterface

// File: rtl/cpu_control.sv
// Multicycle FETCH/DECODE/EXEC control unit for the 16-bit ALU datapath.
// Every output is registered from the next-state decode so it lines up with the state.
module cpu_control (
    input  logic          clk,
    input  logic          reset_n,
    cpu_control_if.master bus
);
    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [15:0] ir_r, ir_s;
    logic [11:0] pc_r, pc_s;
    logic        flag_z_r, flag_z_s;
    logic        flag_c_r, flag_c_s;

    logic        imem_req_r, imem_req_s;
    logic [2:0]  op_alu_r, op_alu_s;
    logic [3:0]  ra_sel_r, ra_sel_s;
    logic [3:0]  rb_sel_r, rb_sel_s;
    logic [3:0]  rd_sel_r, rd_sel_s;
    logic        rf_we_r, rf_we_s;
    logic        wd_sel_r, wd_sel_s;
    logic [15:0] imm_r, imm_s;
    logic        halted_r, halted_s;

    function automatic logic jump_taken(input logic [15:0] ir, input logic fz, input logic fc);
        logic taken;
        case (ir[15:12])
            4'b1000: taken = 1'b1;
            4'b1001: taken = fz;
            4'b1010: taken = ~fz;
            4'b1011: taken = fc;
            4'b1100: taken = ~fc;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    // Next-state, architectural register and flag update logic
    always_comb begin
        state_s  = state_r;
        ir_s     = ir_r;
        pc_s     = pc_r;
        flag_z_s = flag_z_r;
        flag_c_s = flag_c_r;
        case (state_r)
            ST_FETCH: begin
                if (bus.imem_valid) begin
                    ir_s    = bus.imem_rdata;
                    pc_s    = pc_r + 12'd1;
                    state_s = ST_DECODE;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_DECODE: state_s = ST_EXEC;
            ST_EXEC: begin
                if (ir_r[15] == 1'b0) begin
                    flag_z_s = bus.alu_zero;
                    // Only ADD (op 010) produces a meaningful carry
                    if (ir_r[14:12] == 3'b010) begin
                        flag_c_s = bus.alu_carry;
                    end else begin
                        flag_c_s = flag_c_r;
                    end
                end else if (jump_taken(ir_r, flag_z_r, flag_c_r)) begin
                    pc_s = ir_r[11:0];
                end else begin
                    pc_s = pc_r;
                end
                if (ir_r[15:12] == 4'b1111) begin
                    state_s = ST_HALT;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_HALT: state_s = ST_HALT;
            default: state_s = ST_FETCH;
        endcase
    end

    // Output decode for the state being entered, so registered outputs match it
    always_comb begin
        imem_req_s = 1'b0;
        op_alu_s   = 3'b000;
        ra_sel_s   = 4'h0;
        rb_sel_s   = 4'h0;
        rd_sel_s   = 4'h0;
        rf_we_s    = 1'b0;
        wd_sel_s   = 1'b0;
        imm_s      = 16'h0000;
        halted_s   = 1'b0;
        case (state_s)
            ST_FETCH: imem_req_s = 1'b1;
            ST_DECODE, ST_EXEC: begin
                imm_s = {8'h00, ir_s[7:0]};
                if (ir_s[15] == 1'b0) begin
                    op_alu_s = ir_s[14:12];
                    rd_sel_s = ir_s[11:8];
                    ra_sel_s = ir_s[7:4];
                    rb_sel_s = ir_s[3:0];
                    rf_we_s  = (state_s == ST_EXEC);
                    wd_sel_s = 1'b0;
                end else if (ir_s[15:12] == 4'b1101) begin
                    rd_sel_s = ir_s[11:8];
                    rf_we_s  = (state_s == ST_EXEC);
                    wd_sel_s = (state_s == ST_EXEC);
                end else begin
                    rf_we_s = 1'b0;
                end
            end
            ST_HALT: halted_s = 1'b1;
            default: halted_s = 1'b0;
        endcase
    end

    // State, architectural registers and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_FETCH;
            ir_r       <= 16'h0000;
            pc_r       <= 12'h000;
            flag_z_r   <= 1'b0;
            flag_c_r   <= 1'b0;
            imem_req_r <= 1'b1;
            op_alu_r   <= 3'b000;
            ra_sel_r   <= 4'h0;
            rb_sel_r   <= 4'h0;
            rd_sel_r   <= 4'h0;
            rf_we_r    <= 1'b0;
            wd_sel_r   <= 1'b0;
            imm_r      <= 16'h0000;
            halted_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            ir_r       <= ir_s;
            pc_r       <= pc_s;
            flag_z_r   <= flag_z_s;
            flag_c_r   <= flag_c_s;
            imem_req_r <= imem_req_s;
            op_alu_r   <= op_alu_s;
            ra_sel_r   <= ra_sel_s;
            rb_sel_r   <= rb_sel_s;
            rd_sel_r   <= rd_sel_s;
            rf_we_r    <= rf_we_s;
            wd_sel_r   <= wd_sel_s;
            imm_r      <= imm_s;
            halted_r   <= halted_s;
        end
    end

    assign bus.pc       = pc_r;
    assign bus.imem_req = imem_req_r;
    assign bus.op_alu   = op_alu_r;
    assign bus.ra_sel   = ra_sel_r;
    assign bus.rb_sel   = rb_sel_r;
    assign bus.rd_sel   = rd_sel_r;
    assign bus.rf_we    = rf_we_r;
    assign bus.wd_sel   = wd_sel_r;
    assign bus.imm      = imm_r;
    assign bus.flag_z   = flag_z_r;
    assign bus.flag_c   = flag_c_r;
    assign bus.halted   = halted_r;
endmodule

// File: tb/tb_cpu_control.sv
// Directed bench for cpu_control: reset/wait, flags, jumps, LDI, PC wrap, halt, reset mid-EXEC.
module tb_cpu_control;
    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    cpu_control_if bus ();

    cpu_control dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a word with valid, take the accept edge, then drop valid (now in DECODE)
    task automatic fetch(input logic [15:0] w);
        bus.imem_rdata = w;
        bus.imem_valid = 1'b1;
        step();
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 16'h0000;
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        reset_n         = 1'b0;
        bus.imem_rdata  = 16'h0000;
        bus.imem_valid  = 1'b0;
        bus.alu_zero    = 1'b0;
        bus.alu_carry   = 1'b0;
        #3;
        chk("rst_pc", {4'h0, bus.pc}, 16'h0000);
        chk("rst_rf_we", {15'h0, bus.rf_we}, 16'h0000);
        chk("rst_op_alu", {13'h0, bus.op_alu}, 16'h0000);
        chk("rst_flags", {14'h0, bus.flag_z, bus.flag_c}, 16'h0000);
        chk("rst_halted", {15'h0, bus.halted}, 16'h0000);
        chk("rst_imm", bus.imm, 16'h0000);
        step();
        step();
        reset_n = 1'b1;

        // Wait phase: memory not ready for 5 cycles
        for (int i = 0; i < 5; i++) begin
            step();
            chk("wait_req", {15'h0, bus.imem_req}, 16'h0001);
            chk("wait_pc", {4'h0, bus.pc}, 16'h0000);
            chk("wait_rf_we", {15'h0, bus.rf_we}, 16'h0000);
        end

        // ADD r3 <- r1 + r2, zero=1 carry=1
        fetch(16'h2312);
        chk("add_dec_op", {13'h0, bus.op_alu}, 16'h0002);
        chk("add_dec_rd", {12'h0, bus.rd_sel}, 16'h0003);
        chk("add_dec_ra", {12'h0, bus.ra_sel}, 16'h0001);
        chk("add_dec_rb", {12'h0, bus.rb_sel}, 16'h0002);
        chk("add_dec_rf_we", {15'h0, bus.rf_we}, 16'h0000);
        chk("add_dec_req", {15'h0, bus.imem_req}, 16'h0000);
        chk("add_dec_pc", {4'h0, bus.pc}, 16'h0001);
        bus.alu_zero  = 1'b1;
        bus.alu_carry = 1'b1;
        step();
        chk("add_ex_rf_we", {15'h0, bus.rf_we}, 16'h0001);
        chk("add_ex_wd_sel", {15'h0, bus.wd_sel}, 16'h0000);
        chk("add_ex_op", {13'h0, bus.op_alu}, 16'h0002);
        chk("add_ex_req", {15'h0, bus.imem_req}, 16'h0000);
        step();
        chk("add_post_rf_we", {15'h0, bus.rf_we}, 16'h0000);
        chk("add_post_req", {15'h0, bus.imem_req}, 16'h0001);
        chk("add_flags", {14'h0, bus.flag_z, bus.flag_c}, 16'h0003);
        chk("add_post_op", {13'h0, bus.op_alu}, 16'h0000);

        // SUB: zero=0 carry=0, carry flag held
        fetch(16'h3123);
        bus.alu_zero  = 1'b0;
        bus.alu_carry = 1'b0;
        step();
        step();
        chk("sub_flags", {14'h0, bus.flag_z, bus.flag_c}, 16'h0001);
        chk("sub_pc", {4'h0, bus.pc}, 16'h0002);

        // ADD with zero=1 carry=0 -> fz=1 fc=0
        fetch(16'h2312);
        bus.alu_zero  = 1'b1;
        bus.alu_carry = 1'b0;
        step();
        step();
        chk("add2_flags", {14'h0, bus.flag_z, bus.flag_c}, 16'h0002);
        bus.alu_zero  = 1'b0;
        bus.alu_carry = 1'b1;

        // JZ taken
        fetch(16'h9ABC);
        chk("jz_dec_pc", {4'h0, bus.pc}, 16'h0004);
        step();
        chk("jz_ex_rf_we", {15'h0, bus.rf_we}, 16'h0000);
        step();
        chk("jz_pc", {4'h0, bus.pc}, 16'h0ABC);
        chk("jz_flags_kept", {14'h0, bus.flag_z, bus.flag_c}, 16'h0002);

        // JNZ not taken
        fetch(16'hAABC);
        step();
        step();
        chk("jnz_pc", {4'h0, bus.pc}, 16'h0ABD);

        // JC not taken (fc=0), JNC taken
        fetch(16'hB123);
        step();
        step();
        chk("jc_nt_pc", {4'h0, bus.pc}, 16'h0ABE);
        fetch(16'hC123);
        step();
        step();
        chk("jnc_pc", {4'h0, bus.pc}, 16'h0123);

        // ADD zero=0 carry=1, then JC taken
        fetch(16'h2312);
        bus.alu_zero  = 1'b0;
        bus.alu_carry = 1'b1;
        step();
        step();
        chk("add3_flags", {14'h0, bus.flag_z, bus.flag_c}, 16'h0001);
        fetch(16'hB456);
        step();
        step();
        chk("jc_pc", {4'h0, bus.pc}, 16'h0456);

        // LDI r5 <- 0x00A7; ALU inputs changed but flags must hold
        fetch(16'hD5A7);
        bus.alu_zero  = 1'b1;
        bus.alu_carry = 1'b0;
        chk("ldi_dec_rd", {12'h0, bus.rd_sel}, 16'h0005);
        chk("ldi_dec_imm", bus.imm, 16'h00A7);
        chk("ldi_dec_rf_we", {15'h0, bus.rf_we}, 16'h0000);
        step();
        chk("ldi_ex_rf_we", {15'h0, bus.rf_we}, 16'h0001);
        chk("ldi_ex_wd_sel", {15'h0, bus.wd_sel}, 16'h0001);
        chk("ldi_ex_imm", bus.imm, 16'h00A7);
        step();
        chk("ldi_post_rf_we", {15'h0, bus.rf_we}, 16'h0000);
        chk("ldi_flags", {14'h0, bus.flag_z, bus.flag_c}, 16'h0001);
        chk("ldi_pc", {4'h0, bus.pc}, 16'h0457);

        // JMP 0xFFF, NOP at 0xFFF wraps pc to 0x000
        fetch(16'h8FFF);
        step();
        step();
        chk("jmp_pc", {4'h0, bus.pc}, 16'h0FFF);
        fetch(16'hE000);
        chk("wrap_pc", {4'h0, bus.pc}, 16'h0000);
        step();
        chk("nop_rf_we", {15'h0, bus.rf_we}, 16'h0000);
        step();

        // HALT, then held for 20 cycles despite valid requests
        fetch(16'hF000);
        step();
        step();
        bus.imem_valid = 1'b1;
        bus.imem_rdata = 16'h2312;
        for (int i = 0; i < 20; i++) begin
            chk("halt_halted", {15'h0, bus.halted}, 16'h0001);
            chk("halt_req", {15'h0, bus.imem_req}, 16'h0000);
            chk("halt_rf_we", {15'h0, bus.rf_we}, 16'h0000);
            chk("halt_pc", {4'h0, bus.pc}, 16'h0001);
            step();
        end
        bus.imem_valid = 1'b0;

        // Reset exits HALT; then reset during EXEC of an ADD
        reset_n = 1'b0;
        #1;
        chk("rst2_halted", {15'h0, bus.halted}, 16'h0000);
        step();
        reset_n = 1'b1;
        step();
        fetch(16'h2312);
        bus.alu_zero  = 1'b1;
        bus.alu_carry = 1'b1;
        step();
        chk("abort_ex_rf_we", {15'h0, bus.rf_we}, 16'h0001);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_rf_we", {15'h0, bus.rf_we}, 16'h0000);
        chk("abort_flags", {14'h0, bus.flag_z, bus.flag_c}, 16'h0000);
        chk("abort_pc", {4'h0, bus.pc}, 16'h0000);
        step();
        step();
        chk("abort_flags_held", {14'h0, bus.flag_z, bus.flag_c}, 16'h0000);
        chk("abort_rf_we_held", {15'h0, bus.rf_we}, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
